// File: rtl/accel_pkg.sv
// Shared constants and types for the BRAM-to-systolic-array operand path.
// Holds the default widths and read latency, plus the per-lane tag that travels
// alongside each lane's data through the skew pipeline.
package accel_pkg;

  localparam int unsigned DefDataWidth   = 256;
  localparam int unsigned DefNumBits     = 8;
  localparam int unsigned DefLanes       = DefDataWidth / DefNumBits;
  localparam int unsigned DefReadLatency = 2;
  localparam int unsigned DefCntWidth    = 16;

  // Field order fixes the packed layout: valid is the MSB.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } lane_tag_t;

  localparam int unsigned TagWidth = $bits(lane_tag_t);

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line for one systolic-array lane.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset (all stages to 0)
//   clr_i          synchronous clear of every stage
//   d_i / q_o      Width-bit input and output delayed by Depth cycles
//   flag_any_o     OR of bit FlagBit across all stages (in-flight indicator)
// Depth = 0 is a pure passthrough with no storage.
module skew_delay_line #(
  parameter int unsigned Depth   = 1,
  parameter int unsigned Width   = 1,
  parameter int unsigned FlagBit = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             flag_any_o
);

  if (Depth == 0) begin : g_pass
    assign q_o        = d_i;
    assign flag_any_o = 1'b0;
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_ni, clr_i};
  end else begin : g_pipe
    logic [Depth-1:0][Width-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else if (clr_i) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    always_comb begin
      flag_any_o = 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        flag_any_o = flag_any_o | stage_q[i][FlagBit];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/bram_sa_skew_feeder.sv
// Feeds a systolic array from the Port-B read stream of the W/B/I buffer.
// The read enable and tile-end marker are delayed to match the BRAM read latency,
// the returned word is captured with first/last tags, split into lanes, and lane i
// is delayed i further cycles so the array sees a diagonal wavefront.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   bram_en_i         one word read per high cycle
//   fetch_done_i      marks the read of a tile's last word (ignored without bram_en_i)
//   flush_i           synchronous clear of all pipelines, wins over bram_en_i
//   doutb_i           BRAM read data
//   sa_data_o         skewed lanes, lane i at [i*NumBits +: NumBits], 0 when invalid
//   sa_valid_o        per-lane valid
//   tile_start_o      lane 0 carries a tile's first word
//   tile_done_o       last lane carries a tile's last word
//   word_count_o      words emitted on lane 0 in the current tile (saturating)
//   busy_o            any word still in flight
module bram_sa_skew_feeder
  import accel_pkg::*;
#(
  parameter int unsigned DataWidth   = DefDataWidth,
  parameter int unsigned NumBits     = DefNumBits,
  parameter int unsigned ReadLatency = DefReadLatency,
  parameter int unsigned CntWidth    = DefCntWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          bram_en_i,
  input  logic                          fetch_done_i,
  input  logic                          flush_i,
  input  logic [DataWidth-1:0]          doutb_i,
  output logic [DataWidth-1:0]          sa_data_o,
  output logic [DataWidth/NumBits-1:0]  sa_valid_o,
  output logic                          tile_start_o,
  output logic                          tile_done_o,
  output logic [CntWidth-1:0]           word_count_o,
  output logic                          busy_o
);

  localparam int unsigned Lanes = DataWidth / NumBits;
  localparam int unsigned LaneW = NumBits + TagWidth;

  logic [ReadLatency-1:0] en_sr_q, en_sr_d, last_sr_q, last_sr_d;
  lane_tag_t              cap_tag_q, cap_tag_d;
  logic [DataWidth-1:0]   cap_data_q, cap_data_d;
  logic                   first_pend_q, first_pend_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   aln_valid, aln_last;

  always_comb begin
    en_sr_d   = '0;
    last_sr_d = '0;
    if (!flush_i) begin
      en_sr_d[0]   = bram_en_i;
      last_sr_d[0] = bram_en_i & fetch_done_i;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        en_sr_d[i]   = en_sr_q[i-1];
        last_sr_d[i] = last_sr_q[i-1];
      end
    end
  end

  assign aln_valid = en_sr_q[ReadLatency-1];
  assign aln_last  = last_sr_q[ReadLatency-1];

  // Capture stage; the word counter advances here so it lines up with lane 0.
  always_comb begin
    cap_tag_d    = '0;
    cap_data_d   = '0;
    first_pend_d = first_pend_q;
    cnt_d        = cnt_q;
    if (flush_i) begin
      first_pend_d = 1'b1;
      cnt_d        = '0;
    end else if (aln_valid) begin
      cap_tag_d.valid = 1'b1;
      cap_tag_d.first = first_pend_q;
      cap_tag_d.last  = aln_last;
      cap_data_d      = doutb_i;
      first_pend_d    = aln_last;
      if (first_pend_q) begin
        cnt_d = CntWidth'(1);
      end else if (cnt_q != {CntWidth{1'b1}}) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_sr_q      <= '0;
      last_sr_q    <= '0;
      cap_tag_q    <= '0;
      cap_data_q   <= '0;
      first_pend_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      en_sr_q      <= en_sr_d;
      last_sr_q    <= last_sr_d;
      cap_tag_q    <= cap_tag_d;
      cap_data_q   <= cap_data_d;
      first_pend_q <= first_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  logic [Lanes-1:0] lane_valid, lane_first, lane_last, lane_busy;

  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    logic [LaneW-1:0] lane_q;
    lane_tag_t        tag;

    skew_delay_line #(
      .Depth  (g),
      .Width  (LaneW),
      .FlagBit(LaneW - 1)
    ) u_dly (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (flush_i),
      .d_i       ({cap_tag_q, cap_data_q[g*NumBits +: NumBits]}),
      .q_o       (lane_q),
      .flag_any_o(lane_busy[g])
    );

    assign tag = lane_tag_t'(lane_q[LaneW-1 -: TagWidth]);
    // Data is captured as 0 on invalid cycles, so an idle lane already reads 0.
    assign sa_data_o[g*NumBits +: NumBits] = lane_q[NumBits-1:0];
    assign lane_valid[g] = tag.valid;
    assign lane_first[g] = tag.first;
    assign lane_last[g]  = tag.last;
  end

  // Only lane 0's first tag and the last lane's last tag drive outputs.
  logic unused_tags;
  assign unused_tags = ^{lane_first[Lanes-1:1], lane_last[Lanes-2:0]};

  assign sa_valid_o   = lane_valid;
  assign tile_start_o = lane_valid[0] & lane_first[0];
  assign tile_done_o  = lane_valid[Lanes-1] & lane_last[Lanes-1];
  assign word_count_o = cnt_q;
  assign busy_o       = (|en_sr_q) | cap_tag_q.valid | (|lane_busy);

endmodule

// File: tb/tb_bram_sa_skew_feeder.sv
module tb_bram_sa_skew_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         bram_en = 1'b0;
  logic         fetch_done = 1'b0;
  logic         flush = 1'b0;
  logic [255:0] doutb;
  logic [255:0] sa_data;
  logic [31:0]  sa_valid;
  logic         tile_start, tile_done, busy;
  logic [15:0]  word_count;

  bram_sa_skew_feeder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bram_en_i   (bram_en),
    .fetch_done_i(fetch_done),
    .flush_i     (flush),
    .doutb_i     (doutb),
    .sa_data_o   (sa_data),
    .sa_valid_o  (sa_valid),
    .tile_start_o(tile_start),
    .tile_done_o (tile_done),
    .word_count_o(word_count),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: the word requested in cycle c appears on doutb in cycle c+2.
  logic [7:0] din_cur = 8'hEE, din_d1 = 8'hEE, din_d2 = 8'hEE;
  int lane_step = 1;
  always @(posedge clk) begin
    din_d2 <= din_d1;
    din_d1 <= din_cur;
  end
  always_comb begin
    doutb = '0;
    for (int i = 0; i < 32; i++) doutb[i*8 +: 8] = din_d2 + 8'(i * lane_step);
  end

  // Event monitor, sampled on the falling edge.
  int mon_req = 0, mon_ack = 0;
  bit stair_en = 1'b0;
  int n_start = 0, n_done = 0, n_v0 = 0, n_busy = 0, stair_err = 0;
  int t_start[4], t_done[4];
  int t_v0_first = -1, t_v0_last = -1, t_busy_last = -1;
  logic [15:0] wc_start[4];
  logic [7:0]  d_start = 0, d_done = 0;
  bit          rest_zero = 1'b0;
  logic [31:0] prev_v = '0;

  always @(negedge clk) begin
    if (mon_req != mon_ack) begin
      mon_ack = mon_req;
      n_start = 0; n_done = 0; n_v0 = 0; n_busy = 0; stair_err = 0;
      t_v0_first = -1; t_v0_last = -1; t_busy_last = -1;
    end
    if (tile_start) begin
      if (n_start < 4) begin
        t_start[n_start]  = cyc;
        wc_start[n_start] = word_count;
      end
      if (n_start == 0) begin
        d_start   = sa_data[7:0];
        rest_zero = (sa_data[255:8] == '0);
      end
      n_start++;
    end
    if (tile_done) begin
      if (n_done < 4) t_done[n_done] = cyc;
      d_done = sa_data[255:248];
      n_done++;
    end
    if (sa_valid[0]) begin
      if (t_v0_first < 0) t_v0_first = cyc;
      t_v0_last = cyc;
      n_v0++;
    end
    if (busy) begin
      t_busy_last = cyc;
      n_busy++;
    end
    if (stair_en) begin
      for (int i = 1; i < 32; i++) if (sa_valid[i] !== prev_v[i-1]) stair_err++;
    end
    prev_v = sa_valid;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic done, input logic fl, input logic [7:0] din);
    bram_en = en; fetch_done = done; flush = fl; din_cur = din;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 1'b0, 8'hEE);
      next();
    end
  endtask

  task automatic mon_clear();
    mon_req++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_w({tag, "_valid"}, 256'(sa_valid), 256'(0));
    chk_w({tag, "_data"}, sa_data, 256'(0));
    chk_w({tag, "_start"}, 256'(tile_start), 256'(0));
    chk_w({tag, "_done"}, 256'(tile_done), 256'(0));
    chk_w({tag, "_wc"}, 256'(word_count), 256'(0));
    chk_w({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  typedef struct {
    logic       en;
    logic       done;
    logic [7:0] din;
    logic       exp_v0;
    logic [7:0] exp_d0;
    logic       exp_start;
    int         exp_wc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1;
    // Bubble pattern 1,0,1,1,0,1; done on row 1 has no enable and must be ignored.
    vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 4};
    vecs[1] = '{1'b0, 1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 4};
    vecs[2] = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 4};
    vecs[3] = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h11, 1'b1, 1};
    vecs[4] = '{1'b0, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b1, 1'b1, 8'h55, 1'b1, 8'h22, 1'b0, 2};
    vecs[6] = '{1'b0, 1'b0, 8'hEE, 1'b1, 8'h33, 1'b0, 3};
    vecs[7] = '{1'b0, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b0, 3};
    vecs[8] = '{1'b0, 1'b0, 8'hEE, 1'b1, 8'h55, 1'b0, 4};
    vecs[9] = '{1'b0, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b0, 4};

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    next();
    idle(2);

    // Single-word tile
    lane_step = 1;
    mon_clear();
    t0 = cyc;
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    next();
    idle(40);
    chk_i("single_nstart", n_start, 1);
    chk_i("single_start_lat", t_start[0] - t0, 3);
    chk_w("single_lane0", 256'(d_start), 256'h01);
    chk_i("single_idle_lanes_zero", int'(rest_zero), 1);
    chk_i("single_wc_at_start", int'(wc_start[0]), 1);
    chk_i("single_ndone", n_done, 1);
    chk_i("single_done_lat", t_done[0] - t0, 34);
    chk_w("single_lane31", 256'(d_done), 256'h20);
    chk_i("single_busy_last", t_busy_last - t0, 34);
    chk_i("single_wc_end", int'(word_count), 1);

    // 24-word burst, every lane of word k carries k
    lane_step = 0;
    mon_clear();
    stair_en = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, k == 23, 1'b0, 8'(k));
      next();
    end
    idle(40);
    stair_en = 1'b0;
    chk_i("burst_nstart", n_start, 1);
    chk_i("burst_ndone", n_done, 1);
    chk_i("burst_wc", int'(word_count), 24);
    chk_i("burst_nv0", n_v0, 24);
    chk_i("burst_last_v0", t_v0_last - t0, 26);
    chk_i("burst_done_after_v0", t_done[0] - t_v0_last, 31);
    chk_i("burst_staircase_err", stair_err, 0);
    chk_w("burst_lane0_first", 256'(d_start), 256'(0));
    chk_w("burst_lane31_last", 256'(d_done), 256'(23));

    // Back-to-back 4-word tiles
    lane_step = 1;
    mon_clear();
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, (k == 3) || (k == 7), 1'b0, 8'(k));
      next();
    end
    idle(40);
    chk_i("b2b_nstart", n_start, 2);
    chk_i("b2b_start_gap", t_start[1] - t_start[0], 4);
    chk_i("b2b_ndone", n_done, 2);
    chk_i("b2b_done_gap", t_done[1] - t_done[0], 4);
    chk_i("b2b_done0_lat", t_done[0] - t0, 37);
    chk_i("b2b_wc_start0", int'(wc_start[0]), 1);
    chk_i("b2b_wc_start1", int'(wc_start[1]), 1);
    chk_i("b2b_nv0", n_v0, 8);
    chk_i("b2b_v0_span", t_v0_last - t_v0_first, 7);
    chk_i("b2b_wc_end", int'(word_count), 4);

    // Bubbles, table-driven
    mon_clear();
    t0 = cyc;
    for (int r = 0; r < 10; r++) begin
      drive(vecs[r].en, vecs[r].done, 1'b0, vecs[r].din);
      @(negedge clk);
      chk_w($sformatf("bub_v0_r%0d", r), 256'(sa_valid[0]), 256'(vecs[r].exp_v0));
      chk_w($sformatf("bub_d0_r%0d", r), 256'(sa_data[7:0]), 256'(vecs[r].exp_d0));
      chk_w($sformatf("bub_start_r%0d", r), 256'(tile_start), 256'(vecs[r].exp_start));
      chk_i($sformatf("bub_wc_r%0d", r), int'(word_count), vecs[r].exp_wc);
      next();
    end
    idle(40);
    chk_i("bub_ndone", n_done, 1);
    chk_i("bub_done_lat", t_done[0] - t0, 39);

    // Flush mid-tile: 5 words issued, flush arrives with the 6th read
    mon_clear();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + k));
      next();
    end
    drive(1'b1, 1'b0, 1'b1, 8'h45);
    next();
    mon_clear();
    drive(1'b0, 1'b0, 1'b0, 8'hEE);
    @(negedge clk);
    chk_w("flush_valid", 256'(sa_valid), 256'(0));
    chk_w("flush_busy", 256'(busy), 256'(0));
    chk_w("flush_wc", 256'(word_count), 256'(0));
    next();
    idle(3);
    t1 = cyc;
    drive(1'b1, 1'b1, 1'b0, 8'h60);
    next();
    idle(40);
    chk_i("flush_nstart", n_start, 1);
    chk_i("flush_start_lat", t_start[0] - t1, 3);
    chk_w("flush_new_lane0", 256'(d_start), 256'h60);
    chk_i("flush_ndone", n_done, 1);
    chk_i("flush_done_lat", t_done[0] - t1, 34);

    // Asynchronous reset mid-burst
    mon_clear();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(k));
      next();
    end
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'hEE);
    #1;
    chk_all_zero("areset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next();
    mon_clear();
    idle(40);
    chk_i("areset_nbusy", n_busy, 0);
    chk_i("areset_nstart", n_start, 0);
    chk_i("areset_ndone", n_done, 0);
    chk_i("areset_wc", int'(word_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_sa_skew_feeder.md
Name: bram_sa_skew_feeder

Overview:
- Consumes the 256-bit Port-B read stream of the W/B/I buffer, as driven by the fetch logic's bram_en and fetch_done.
- Realigns each word to the BRAM read latency and splits it into NUM_BITS-wide lanes.
- Applies diagonal skew (lane i delayed i cycles) so the systolic array receives wavefront-ordered operands.
- Produces per-lane valid, tile start/done markers and a word count, all timed to the skewed output.

Parameters:
- DATA_WIDTH, 256, BRAM read word width.
- NUM_BITS, 8, width of one quantized element.
- LANES, DATA_WIDTH/NUM_BITS (32), systolic array rows fed; derived, not overridden.
- READ_LATENCY, 2, cycles from bram_en high to valid doutb; legal range 1..3.
- CNT_WIDTH, 16, width of the word counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bram_en  input  1  read enable issued by the fetch logic; one word read per high cycle.
- fetch_done  input  1  pulse coincident with the bram_en cycle of a tile's last read.
- flush  input  1  synchronous clear of all pipelines; has priority over bram_en.
- doutb  input  DATA_WIDTH  BRAM Port-B read data.
- sa_data  output  DATA_WIDTH  skewed lanes; lane i = sa_data[i*NUM_BITS +: NUM_BITS].
- sa_valid  output  LANES  per-lane valid.
- tile_start  output  1  pulse with the lane-0 output of a tile's first word.
- tile_done  output  1  pulse with the lane LANES-1 output of a tile's last word.
- word_count  output  CNT_WIDTH  words emitted on lane 0 in the current tile.
- busy  output  1  high while any word is in flight.

Behaviour:
- Reset: every output is 0 and all pipelines are cleared. Reset may assert mid-tile; no partial tile resumes afterwards.
- Latency alignment:
  - bram_en and fetch_done each pass through a READ_LATENCY-deep shift register.
  - The aligned valid samples doutb in cycle T+READ_LATENCY, where T is the bram_en cycle.
  - The captured word is registered at the end of that cycle, with a first flag and a last flag.
  - The first flag is set for the first valid word after reset, flush, or a word carrying last.
- Skew:
  - Lane i, with its valid, first and last tags, passes through i further registers.
  - Lane 0 appears in cycle T+READ_LATENCY+1. Lane i appears in cycle T+READ_LATENCY+1+i.
  - A lane whose valid is low outputs data 0.
- Throughput: one word per cycle sustained; back-to-back tiles need no bubble. A new tile's lane 0 may overlap the previous tile's drain.
- tile_start: 1-cycle pulse when lane-0 valid and first are both high.
- tile_done: 1-cycle pulse when lane LANES-1 valid and last are both high. A 1-word tile produces tile_start and tile_done LANES-1 cycles apart.
- word_count:
  - On a tile_start cycle it loads 1; otherwise it increments on each lane-0 valid.
  - It holds after the last word until the next tile_start.
  - It saturates at all-ones (no wrap).
- busy: OR of all in-flight valid bits (alignment shift register and all skew stages). It falls the cycle after the final lane's valid output.
- flush: clears all shift registers, tags and word_count on the next edge. Pulses in flight are suppressed. flush together with bram_en: the read is discarded.
- fetch_done without bram_en in the same cycle: ignored.
- Width: internal lane tags are 1 bit each. Skew storage is LANES*(LANES-1)/2 lane registers and is not to be compressed into RAM.

Decomposition:
- Shared package (accel_pkg): NUM_BITS, DATA_WIDTH, LANES, READ_LATENCY defaults, plus a lane_tag struct of {valid, first, last}.
- One sub-module: skew_delay_line, parameterized by DEPTH and WIDTH, reset to 0 and instantiated per lane via generate. Lane 0 uses DEPTH=0 as a passthrough.

Test Plan:
- Single word: bram_en and fetch_done high for 1 cycle at cycle 10 with doutb lane i = i+1 → lane0 = 8'h01 at cycle 13 with tile_start; lane31 = 8'h20 at cycle 44 with tile_done; busy low from cycle 45; word_count = 1.
- Burst of 24 words (16 rows×... tile of 24 reads, fetch_done on the 24th), lanes = word index → sa_valid forms a diagonal staircase; word_count reaches 24; exactly one tile_start and one tile_done, with tile_done 31 cycles after the last lane-0 word.
- Back-to-back tiles: 4 words (last on the 4th), then 4 words immediately → two tile_start 4 cycles apart, two tile_done 4 cycles apart, no gap in lane-0 valid, word_count reloads to 1.
- Bubbles: bram_en pattern 1,0,1,1,0,1 → sa_valid lane0 reproduces the pattern shifted by 3 cycles; idle lanes output 0.
- Flush mid-tile: flush after 5 of 10 words in flight → all sa_valid low next cycle, no tile_done, word_count = 0; the next read is flagged tile_start.
- Async reset: rst_n low mid-burst, asynchronously between edges → all outputs 0 immediately; after release with bram_en idle, busy stays 0.
